// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and default sizes for the FIR MAC sequencer.
//                Holds the sequencer state encoding, the default sample and
//                accumulator widths, and the latency of the downstream MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_W  = 16;
    localparam int ACC_W   = 33;
    localparam int MAC_LAT = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } fir_state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : fir_delay_line
//  Description : NTAPS-deep circular sample buffer. A sample is written at the
//                write pointer; the pointer only moves on i_advance, so while a
//                filter pass is running, offset 0 of the read port is the
//                newest sample and offset k is the sample k steps older.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                i_wr_en        - write i_wr_data at the write pointer
//                i_advance      - step the write pointer (modulo NTAPS)
//                i_clear        - zero every entry and the write pointer
//                i_tap          - read offset k behind the write pointer
//                o_rd_data      - combinational read data x[n-k]
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_delay_line #(
    parameter int NTAPS  = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_advance,
    input  logic                     i_clear,
    input  logic [$clog2(NTAPS)-1:0] i_tap,
    output logic [DATA_W-1:0]        o_rd_data
);
    import fir_pkg::*;

    localparam int AW = $clog2(NTAPS);

    logic [DATA_W-1:0] r_buf [NTAPS];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     w_rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_buf[r_wr_ptr] <= i_wr_data;
            end
            if (i_advance) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // NTAPS is a power of two, so the subtraction wraps modulo NTAPS for free.
    assign w_rd_idx  = r_wr_ptr - i_tap;
    assign o_rd_data = r_buf[w_rd_idx];

endmodule : fir_delay_line
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Feeds an external pipelined MAC one sample/coefficient pair
//                per tap, chaining the partial sum back through prevValue,
//                and presents the finished FIR sum on a valid/ready output.
//                Optional macro FIR_CLEAR_EN adds clear_i, which zeroes the
//                delay line and its pointer while idle.
//  Ports       : clk_i, rst_i              - clock, async active-high reset
//                sample_i/_valid_i/_ready_o- input sample handshake
//                coeff_we_i/_waddr_i/_wdata_i - coefficient write port
//                mac_clk_en_o, mac_prev_o, mac_a_o, mac_b_o - MAC drive
//                mac_result_i              - MAC result
//                out_o/_valid_o, out_ready_i - filter output handshake
//                clear_i (FIR_CLEAR_EN only) - delay-line clear
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int NTAPS   = 16,
    parameter int MAC_LAT = fir_pkg::MAC_LAT,
    parameter int DATA_W  = fir_pkg::DATA_W,
    parameter int ACC_W   = fir_pkg::ACC_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
`ifdef FIR_CLEAR_EN
    input  logic                     clear_i,
`endif
    input  logic [DATA_W-1:0]        sample_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    input  logic                     coeff_we_i,
    input  logic [$clog2(NTAPS)-1:0] coeff_waddr_i,
    input  logic [DATA_W-1:0]        coeff_wdata_i,
    output logic                     mac_clk_en_o,
    output logic [ACC_W-1:0]         mac_prev_o,
    output logic [DATA_W-1:0]        mac_a_o,
    output logic [DATA_W-1:0]        mac_b_o,
    input  logic [ACC_W-1:0]         mac_result_i,
    output logic [ACC_W-1:0]         out_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);
    import fir_pkg::*;

    localparam int AW  = $clog2(NTAPS);
    localparam int WCW = $clog2(MAC_LAT + 1);

    localparam logic [AW-1:0]  c_last_tap = AW'(NTAPS - 1);
    // Between taps the next ISSUE lines up with the previous result, so the
    // wait is one cycle shorter than the MAC latency; after the final tap we
    // wait the full latency so the last result can be captured.
    localparam logic [WCW-1:0] c_wait_mid = WCW'(MAC_LAT - 2);
    localparam logic [WCW-1:0] c_wait_end = WCW'(MAC_LAT - 1);

    fir_state_t         r_state;
    fir_state_t         w_next;
    logic [AW-1:0]      r_k;
    logic [WCW-1:0]     r_wcnt;
    logic [ACC_W-1:0]   r_out;
    logic [DATA_W-1:0]  r_coeff [NTAPS];

    logic               w_clear;
    logic               w_accept;
    logic               w_tap_next;
    logic               w_capture;
    logic [DATA_W-1:0]  w_sample_rd;

`ifdef FIR_CLEAR_EN
    assign w_clear = clear_i & (r_state == S_IDLE);
`else
    assign w_clear = 1'b0;
`endif

    // A clear in the same cycle as a valid sample suppresses the accept.
    assign w_accept = (r_state == S_IDLE) & sample_valid_i & ~w_clear;

    fir_delay_line #(
        .NTAPS  (NTAPS),
        .DATA_W (DATA_W)
    ) u_delay_line (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_wr_en   (w_accept),
        .i_wr_data (sample_i),
        .i_advance (w_capture),
        .i_clear   (w_clear),
        .i_tap     (r_k),
        .o_rd_data (w_sample_rd)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next     = r_state;
        w_tap_next = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_k != c_last_tap) begin
                    if (r_wcnt == c_wait_mid) begin
                        w_next     = S_ISSUE;
                        w_tap_next = 1'b1;
                    end
                end else if (r_wcnt == c_wait_end) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        sample_ready_o = (r_state == S_IDLE) & ~w_clear;
        out_valid_o    = (r_state == S_DONE);
        mac_clk_en_o   = (r_state == S_ISSUE) | (r_state == S_WAIT);
        mac_a_o        = '0;
        mac_b_o        = '0;
        mac_prev_o     = '0;
        if (r_state == S_ISSUE) begin
            mac_a_o = w_sample_rd;
            mac_b_o = r_coeff[r_k];
            // Tap 0 starts a fresh sum; later taps chain the running total.
            if (r_k != '0) begin
                mac_prev_o = mac_result_i;
            end
        end
    end

    assign out_o = r_out;

    // ---------------- tap / wait counters and result ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_k    <= '0;
            r_wcnt <= '0;
            r_out  <= '0;
        end else begin
            if (w_accept) begin
                r_k <= '0;
            end else if (w_tap_next) begin
                r_k <= r_k + 1'b1;
            end

            if (r_state == S_ISSUE) begin
                r_wcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end

            if (w_capture) begin
                r_out <= mac_result_i;
            end
        end
    end

    // ---------------- coefficient file ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coeff[i] <= '0;
            end
        end else if (coeff_we_i) begin
            r_coeff[coeff_waddr_i] <= coeff_wdata_i;
        end
    end

endmodule : fir_mac_sequencer
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sequencer
//  Description : Self-checking bench for fir_mac_sequencer with a behavioural
//                3-cycle pipelined MAC attached to the MAC-side ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] sample_i = '0;
    logic        sample_valid_i = 1'b0;
    logic        sample_ready_o;
    logic        coeff_we_i = 1'b0;
    logic [3:0]  coeff_waddr_i = '0;
    logic [15:0] coeff_wdata_i = '0;
    logic        mac_clk_en_o;
    logic [32:0] mac_prev_o;
    logic [15:0] mac_a_o;
    logic [15:0] mac_b_o;
    logic [32:0] mac_result_i;
    logic [32:0] out_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
`ifdef FIR_CLEAR_EN
    logic        clear_i = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
`ifdef FIR_CLEAR_EN
        .clear_i        (clear_i),
`endif
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .coeff_we_i     (coeff_we_i),
        .coeff_waddr_i  (coeff_waddr_i),
        .coeff_wdata_i  (coeff_wdata_i),
        .mac_clk_en_o   (mac_clk_en_o),
        .mac_prev_o     (mac_prev_o),
        .mac_a_o        (mac_a_o),
        .mac_b_o        (mac_b_o),
        .mac_result_i   (mac_result_i),
        .out_o          (out_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i)
    );

    // Behavioural MAC: result_o = prevValue + a*b, three enabled cycles later.
    logic [32:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        if (mac_clk_en_o) begin
            p1 <= mac_prev_o + 33'(mac_a_o) * 33'(mac_b_o);
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign mac_result_i = p3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coeff(input logic [3:0] a, input logic [15:0] d);
        coeff_we_i    = 1'b1;
        coeff_waddr_i = a;
        coeff_wdata_i = d;
        tick();
        coeff_we_i    = 1'b0;
    endtask

    // mode 1: ramp k+1, mode 2: all ones, mode 3: all 0xFFFF
    task automatic load_coeffs(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                1:       write_coeff(4'(k), 16'(k + 1));
                2:       write_coeff(4'(k), 16'd1);
                default: write_coeff(4'(k), 16'hFFFF);
            endcase
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic run_sample(input logic [15:0] s, output logic [32:0] y, output logic ok);
        int n;
        n = 0;
        while (!sample_ready_o && n < 100) begin
            tick();
            n++;
        end
        sample_i       = s;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 200) begin
            tick();
            n++;
        end
        ok = out_valid_o;
        y  = out_o;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    typedef struct {
        bit          do_rst;
        int          cmode;
        logic [15:0] sample;
        logic [32:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic apply_rows(input int lo, input int hi);
        logic [32:0] y;
        logic        ok;
        for (int i = lo; i < hi; i++) begin
            if (tbl[i].do_rst) do_reset();
            if (tbl[i].cmode != 0) load_coeffs(tbl[i].cmode);
            run_sample(tbl[i].sample, y, ok);
            chk($sformatf("row%0d_valid", i), 64'(ok), 64'd1);
            chk($sformatf("row%0d_out", i), 64'(y), 64'(tbl[i].exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [32:0] y;
        logic        ok;
        logic [63:0] t;
        int          n_first;
        int          cyc;
        int          first;
        int          n;

        // Impulse response with coeff[k] = k+1
        tbl.push_back('{1'b0, 1, 16'd1, 33'd1});
        for (int i = 1; i < 16; i++) tbl.push_back('{1'b0, 0, 16'd0, 33'(i + 1)});
        // Step response with all coefficients 1
        for (int i = 0; i < 17; i++)
            tbl.push_back('{1'b0, (i == 0) ? 2 : 0, 16'd100, 33'(100 * ((i < 16) ? i + 1 : 16))});
        n_first = tbl.size();
        // Wrap arithmetic after a fresh reset
        for (int i = 0; i < 16; i++) begin
            t = 64'(i + 1) * 64'hFFFE0001;
            tbl.push_back('{(i == 0), (i == 0) ? 3 : 0, 16'hFFFF, t[32:0]});
        end
        tbl[tbl.size() - 1].exp = 33'h1FFE00010;

        // ---- reset state ----
        tick();
        chk("rst_ready", 64'(sample_ready_o), 64'd1);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out", 64'(out_o), 64'd0);
        chk("rst_clk_en", 64'(mac_clk_en_o), 64'd0);
        chk("rst_mac_ab", 64'({mac_a_o, mac_b_o}), 64'd0);
        chk("rst_prev", 64'(mac_prev_o), 64'd0);
        rst_i = 1'b0;
        tick();

        apply_rows(0, n_first);

        // ---- latency and mid-computation coefficient write ----
        sample_i       = 16'd100;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        cyc   = 1;
        first = -1;
        while (cyc <= 60 && first < 0) begin
            coeff_we_i    = (cyc == 5);
            coeff_waddr_i = 4'd15;
            coeff_wdata_i = 16'd5;
            if (cyc == 1) begin
                chk("issue0_a", 64'(mac_a_o), 64'd100);
                chk("issue0_b", 64'(mac_b_o), 64'd1);
                chk("issue0_prev", 64'(mac_prev_o), 64'd0);
                chk("issue0_en", 64'(mac_clk_en_o), 64'd1);
            end
            if (cyc == 2) chk("wait_a_zero", 64'(mac_a_o), 64'd0);
            if (cyc == 49) chk("valid_not_early", 64'(out_valid_o), 64'd0);
            if (out_valid_o) first = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        coeff_we_i = 1'b0;
        chk("latency", 64'(first), 64'd50);
        chk("lat_out", 64'(out_o), 64'd2000);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // ---- backpressure ----
        sample_i       = 16'd100;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("bp_valid", 64'(out_valid_o), 64'd1);
        sample_i       = 16'h7777;
        sample_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_hold", 64'(out_o), 64'd2000);
            chk("bp_ready_low", 64'(sample_ready_o), 64'd0);
            tick();
        end
        sample_valid_i = 1'b0;
        out_ready_i    = 1'b1;
        tick();
        out_ready_i    = 1'b0;
        chk("bp_back_idle", 64'(sample_ready_o), 64'd1);
        run_sample(16'd100, y, ok);
        chk("bp_no_accept", 64'(y), 64'd2000);

        apply_rows(n_first, tbl.size());

        // ---- reset in the middle of a computation ----
        sample_i       = 16'd1;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        repeat (19) tick();
        chk("pre_rst_busy", 64'(mac_clk_en_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_en", 64'(mac_clk_en_o), 64'd0);
        chk("mid_rst_mac", 64'({mac_a_o, mac_b_o}), 64'd0);
        chk("mid_rst_prev", 64'(mac_prev_o), 64'd0);
        chk("mid_rst_out", 64'({out_valid_o, out_o}), 64'd0);
        chk("mid_rst_ready", 64'(sample_ready_o), 64'd1);
        tick();
        rst_i = 1'b0;
        tick();
        write_coeff(4'd0, 16'd7);
        write_coeff(4'd1, 16'd3);
        run_sample(16'd1, y, ok);
        chk("post_rst_valid", 64'(ok), 64'd1);
        chk("post_rst_out", 64'(y), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fir_mac_sequencer
`default_nettype wire

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control stage placed directly upstream of the 3-cycle pipelined 16x16 MAC (33-bit accumulate). It accepts one audio sample per handshake and stores it in an NTAPS-deep circular delay line. It then issues one sample/coefficient pair per tap to the MAC, closing the accumulation loop through the MAC's `prevValue` input, and presents the finished 33-bit FIR sum on a valid/ready output. Coefficients live in an internal register file that is written through a simple write port.

## Interface
- `NTAPS`, 16: filter length; power of two, ≥2.
- `MAC_LAT`, 3: MAC input-to-`result_o` latency in cycles.
- `DATA_W`, 16: sample and coefficient width.
- `ACC_W`, 33: accumulator/result width.

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `sample_i` in DATA_W: input sample.
- `sample_valid_i` in 1: sample present.
- `sample_ready_o` out 1: block can accept a sample.
- `coeff_we_i` in 1: coefficient write strobe.
- `coeff_waddr_i` in log2(NTAPS): tap index to write.
- `coeff_wdata_i` in DATA_W: coefficient value.
- `mac_clk_en_o` out 1: drives MAC `clk_en_i`.
- `mac_prev_o` out ACC_W: drives MAC `prevValue`.
- `mac_a_o` out DATA_W: drives MAC `data_a_i` (sample).
- `mac_b_o` out DATA_W: drives MAC `data_b_i` (coefficient).
- `mac_result_i` in ACC_W: MAC `result_o`.
- `out_o` out ACC_W: filter output y[n].
- `out_valid_o` out 1: output valid.
- `out_ready_i` in 1: consumer accepts output.

## Operation
- FSM states IDLE, ISSUE, WAIT, DONE.
- IDLE: `sample_ready_o`=1. On `sample_valid_i`&`sample_ready_o`, write the sample to `buf[wr_ptr]`, reset tap counter k to 0, go to ISSUE. `wr_ptr` advances after the tap loop, modulo NTAPS, and wraps silently.
- ISSUE (one cycle per tap): `mac_a_o`=`buf[(wr_ptr−k) mod NTAPS]` (x[n−k]), `mac_b_o`=`coeff[k]`, `mac_prev_o`=0 if k=0, else `mac_result_i`. Then go to WAIT.
- WAIT: count MAC_LAT−1 cycles. Then, if k<NTAPS−1, increment k and go to ISSUE. Otherwise register `mac_result_i` into `out_o` on the cycle it becomes valid and go to DONE.
- DONE: `out_valid_o`=1 and `out_o` is held. On `out_ready_i`, go to IDLE the next cycle. No sample is accepted in DONE.
- `mac_a_o`/`mac_b_o`/`mac_prev_o` are zero outside ISSUE. `mac_clk_en_o`=1 in ISSUE/WAIT, 0 otherwise.
- Arithmetic is performed by the MAC: unsigned, modulo 2^ACC_W. Overflow wraps and is not flagged.
- A coefficient write in cycle c is visible to any ISSUE from cycle c+1. Writes are allowed in every state.
- Reset (async, any state): state IDLE, `wr_ptr`=0, delay line and coefficients cleared to 0.
  - Reset values: `out_o`=0, `out_valid_o`=0, all `mac_*_o`=0, `sample_ready_o`=1.
  - An in-flight computation is discarded.

## Timing
- A handshake in cycle 0 gives ISSUE of tap k in cycle 1+k·MAC_LAT.
- The final sum is on `mac_result_i` in cycle 1+NTAPS·MAC_LAT.
- `out_valid_o` rises in cycle 2+NTAPS·MAC_LAT (50 for the defaults).
- The earliest next accept is the cycle after the `out_ready_i` handshake.
- Throughput: one sample per NTAPS·MAC_LAT+3 cycles with no backpressure.

## Configuration
- `FIR_CLEAR_EN` defined:
  - Adds input `clear_i`, width 1.
  - `clear_i` high in IDLE zeroes all delay-line entries and `wr_ptr` in one cycle.
  - If `sample_valid_i` is high in the same cycle, `clear_i` wins: no accept that cycle.
  - `clear_i` is ignored in other states.
- Undefined: no port. The delay line is cleared only by `rst_i`.

## Structure
- Package `fir_pkg`:
  - state enum `fir_state_t`
  - default widths `DATA_W`/`ACC_W`
  - `MAC_LAT` constant
- Sub-module `fir_delay_line`: circular sample buffer with write pointer, indexed read port and clear.
- The FSM and coefficient file stay in the top level.

## Test plan
- Impulse response: coeff[k]=k+1, sample 1 followed by 15 zeros → outputs 1,2,…,16.
- Step response: all coeffs 1, samples constant 100 → outputs 100,200,…,1600, then 1600 steady.
- Wrap arithmetic: all coeffs and samples 0xFFFF; the 16th output is 0x1FFE00010 (mod 2^33).
- Backpressure: hold `out_ready_i` low for 10 cycles → `out_o` stable, `sample_ready_o`=0, no accept with `sample_valid_i` high.
- Latency check: accept in cycle 0 → `out_valid_o` first high in cycle 50. A coefficient write to tap 15 in cycle 5 is used by that same output.
- Reset mid-compute: assert `rst_i` in cycle 20 → all outputs 0 immediately. A subsequent impulse with coeff[0]=7 gives first output 7, with no residue.
